regfile_dump: RTL and testbench
===============================

# regfile_dump

Sequencer that reads a contiguous, optionally wrapping, range of the register file through one asynchronous read port. It streams each word, tagged with its address, out over a valid/ready interface. It is the reader-side counterpart of the register file and is used for debug dumps and context save. It owns one register-file read address port and never writes the file.

## Interface
Parameters:
- WIDTH, 16, data width of a register.
- REGBITS, 4, register address width; the file holds 2^REGBITS entries.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a dump; sampled only in IDLE.
- abort  input  1  cancel a dump in progress.
- first  input  REGBITS  first address of the range; latched on an accepted start.
- last  input  REGBITS  last address of the range; latched on an accepted start.
- ra  output  REGBITS  address to the register-file read port.
- rd  input  WIDTH  combinational read data for ra; register 0 reads as 0, supplied by the file.
- out_valid  output  1  out_data and out_addr hold a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  captured register value.
- out_addr  output  REGBITS  address out_data was read from.
- busy  output  1  high in FETCH and SEND.
- done  output  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 latches first into the address counter (addr) and last into end_addr, then moves to FETCH.
  - start is ignored in every other state.
- FETCH:
  - ra=addr, and rd is combinational.
  - At the clock edge: out_data<=rd, out_addr<=addr, then SEND.
- SEND:
  - out_valid=1.
  - out_valid=1 && out_ready=1 is a handshake. If addr==end_addr, go to DONE; otherwise addr<=addr+1 and go to FETCH.
  - With no handshake, SEND holds. out_data and out_addr stay stable.
- DONE: done=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^REGBITS. If first > last, the range wraps from 2^REGBITS-1 to 0.
- Word count is ((last-first) mod 2^REGBITS)+1. first==last gives exactly one word, never a full sweep.
- abort=1 in FETCH or SEND:
  - The next state is IDLE and out_valid drops. The word in flight is lost and done is not pulsed.
  - abort has priority over a simultaneous handshake.
  - abort in IDLE or DONE has no effect.
- ra reflects addr in every state. In IDLE it holds the last value used.
- reset, asynchronous at any time including mid-dump:
  - state=IDLE, addr=0, end_addr=0.
  - out_data=0, out_addr=0.
  - out_valid=0, busy=0, done=0, ra=0.

## Timing
- start high in cycle 0 (IDLE):
  - Cycle 1 is FETCH with ra=first.
  - Cycle 2 is SEND with out_valid=1 and out_data=RAM[first].
- Throughput: one word every 2 cycles when out_ready is held high. N words take 2N cycles from FETCH entry.
- done is asserted in the cycle after the final handshake. IDLE can accept a new start two cycles after the final handshake.
- Latency from start to the first out_valid is 2 cycles.
- Outputs are registered except ra, busy and done, which are decoded from state/addr with no input-to-output combinational path.
- out_ready is not required to be low outside SEND; it is ignored there.
- rd must settle within one cycle of ra changing, which the register file's asynchronous read guarantees.

## Structure
- Shared package regfile_pkg holds:
  - WIDTH and REGBITS defaults.
  - The dump state enum (IDLE, FETCH, SEND, DONE).
- No sub-module. One FSM, an address counter, an end-address register and the output register fit in a single module.
- Top level instantiates regfile_dump beside the register file. ra/rd connect to the file's rd1 port through a mux owned by the top level.

## Test plan
- Reset mid-SEND:
  - Assert reset while out_valid=1.
  - Required: out_valid, busy and done are 0 immediately (asynchronous), ra=0, and the state is IDLE after release.
- Basic dump:
  - Stimulus: file preloaded with RAM[i]=16'h1000+i, first=2, last=5, out_ready=1.
  - Required: words (2,16'h1002), (3,16'h1003), (4,16'h1004), (5,16'h1005) on cycles 2, 4, 6, 8 after start; done pulse on cycle 9.
- Wrap and register 0:
  - Stimulus: first=14, last=1.
  - Required: addresses 14, 15, 0, 1 in order, with out_data for address 0 equal to 16'h0000.
- Single word:
  - Stimulus: first=last=7.
  - Required: exactly one word (7,16'h1007), then done.
- Backpressure and start while busy:
  - Stimulus: out_ready low for 5 cycles in SEND, and start pulsed during that stall.
  - Required: out_data is stable and out_valid stays high, the word is accepted once out_ready rises, and the stray start changes nothing.
- Abort:
  - Stimulus: abort together with out_ready=1 in the SEND of the 2nd word of range 0..9.
  - Required: IDLE on the next cycle, out_valid=0, no done pulse, and a fresh start with 3..3 works normally.

Source files
------------

// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// Module      : regfile_pkg
// Description : Shared defaults and dump-sequencer state encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_REGBITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_dump_if.sv
//------------------------------------------------------------------------------
// Module      : regfile_dump_if
// Description : Valid/ready word stream carrying register data and its address.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface regfile_dump_if
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int REGBITS = DEF_REGBITS
);
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [REGBITS-1:0] out_addr;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/regfile_dump.sv
//------------------------------------------------------------------------------
// Module      : regfile_dump
// Description : Streams a contiguous (optionally wrapping) register range out
//               over valid/ready, reading through one async read port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_dump
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int REGBITS = DEF_REGBITS
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               start,
    input  wire logic               abort,
    input  wire logic [REGBITS-1:0] first,
    input  wire logic [REGBITS-1:0] last,
    output logic      [REGBITS-1:0] ra,
    input  wire logic [WIDTH-1:0]   rd,
    regfile_dump_if.master          stream,
    output logic                    busy,
    output logic                    done
);

    localparam logic [REGBITS-1:0] C_ONE = {{(REGBITS-1){1'b0}}, 1'b1};

    dump_state_t        r_state;
    dump_state_t        w_next_state;
    logic [REGBITS-1:0] r_addr;
    logic [REGBITS-1:0] r_end_addr;
    logic [WIDTH-1:0]   r_out_data;
    logic [REGBITS-1:0] r_out_addr;
    logic               r_out_valid;
    logic               w_handshake;
    logic               w_at_end;

    assign w_handshake = r_out_valid && stream.out_ready;
    assign w_at_end    = (r_addr == r_end_addr);

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_FETCH;
            ST_FETCH: w_next_state = abort ? ST_IDLE : ST_SEND;
            ST_SEND: begin
                // abort wins over a simultaneous handshake
                if (abort)
                    w_next_state = ST_IDLE;
                else if (w_handshake)
                    w_next_state = w_at_end ? ST_DONE : ST_FETCH;
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_end_addr  <= '0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= (w_next_state == ST_SEND);
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr     <= first;
                        r_end_addr <= last;
                    end
                end
                ST_FETCH: begin
                    if (!abort) begin
                        r_out_data <= rd;
                        r_out_addr <= r_addr;
                    end
                end
                ST_SEND: begin
                    if (!abort && w_handshake && !w_at_end)
                        r_addr <= r_addr + C_ONE;
                end
                default: ;
            endcase
        end
    end

    assign ra               = r_addr;
    assign busy             = (r_state == ST_FETCH) || (r_state == ST_SEND);
    assign done             = (r_state == ST_DONE);
    assign stream.out_valid = r_out_valid;
    assign stream.out_data  = r_out_data;
    assign stream.out_addr  = r_out_addr;

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump.sv
//------------------------------------------------------------------------------
// Module      : tb_regfile_dump
// Description : Self-checking bench for regfile_dump against a range model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_dump;
    import regfile_pkg::*;

    localparam int W    = DEF_WIDTH;
    localparam int RB   = DEF_REGBITS;
    localparam int NREG = 1 << RB;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [RB-1:0] first = '0;
    logic [RB-1:0] last  = '0;
    logic [RB-1:0] ra;
    logic [W-1:0]  rd;
    logic          busy;
    logic          done;

    logic [W-1:0]  mem [NREG];

    int n_vec = 0;
    int n_err = 0;

    regfile_dump_if #(.WIDTH(W), .REGBITS(RB)) bus ();

    regfile_dump #(.WIDTH(W), .REGBITS(RB)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .first  (first),
        .last   (last),
        .ra     (ra),
        .rd     (rd),
        .stream (bus),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Register file read port: register 0 always reads as zero
    always_comb rd = (ra == '0) ? '0 : mem[ra];

    function automatic logic [W-1:0] file_word(input int a);
        return (a == 0) ? '0 : mem[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One dump of first..last; expected words come from the range rule.
    task automatic do_dump(input int f, input int l, input int ready_pct,
                           input int hold_idx, input bit stray);
        int            exp_addr[$];
        int            n, idx, cyc, hold;
        bit            prev_stall;
        bit            timed;
        logic [W-1:0]  prev_data;
        logic [RB-1:0] prev_addr;

        n = (((l - f) % NREG) + NREG) % NREG + 1;
        for (int i = 0; i < n; i++) exp_addr.push_back((f + i) % NREG);
        timed = (ready_pct >= 100) && (hold_idx < 0) && !stray;

        first = RB'(f);
        last  = RB'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        chk("fetch_busy",  {31'd0, busy}, 32'd1);
        chk("fetch_valid", {31'd0, bus.out_valid}, 32'd0);

        idx = 0; hold = 0; prev_stall = 1'b0;
        prev_data = '0; prev_addr = '0;
        while (idx < n && cyc < 400) begin
            if (stray) begin
                start = ($urandom_range(3) == 0);
                first = RB'($urandom);
                last  = RB'($urandom);
            end
            if (busy && !bus.out_valid)
                chk("fetch_ra", {28'd0, ra}, exp_addr[idx]);
            if (bus.out_valid) begin
                if (prev_stall) begin
                    chk("stall_data", {16'd0, bus.out_data}, {16'd0, prev_data});
                    chk("stall_addr", {28'd0, bus.out_addr}, {28'd0, prev_addr});
                end
                if (idx == hold_idx && hold < 5) begin
                    bus.out_ready = 1'b0;
                    hold++;
                    start = 1'b1;
                    first = RB'($urandom);
                    last  = RB'($urandom);
                end else begin
                    bus.out_ready = ($urandom_range(99) < ready_pct);
                end
                if (bus.out_ready) begin
                    chk("word_addr", {28'd0, bus.out_addr}, exp_addr[idx]);
                    chk("word_data", {16'd0, bus.out_data}, {16'd0, file_word(exp_addr[idx])});
                    if (timed) chk("word_cycle", cyc, 2 + 2 * idx);
                    idx++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = bus.out_data;
                    prev_addr  = bus.out_addr;
                end
            end else begin
                bus.out_ready = ($urandom_range(1) == 1);
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        bus.out_ready = 1'b0;
        if (idx < n) chk("dump_timeout", idx, n);

        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("done_busy",  {31'd0, busy}, 32'd0);
        if (timed) chk("done_cycle", cyc, 2 * n + 1);
        tick();
        chk("done_clear", {31'd0, done}, 32'd0);
        chk("idle_busy",  {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.out_ready = 1'b0;
        for (int i = 0; i < NREG; i++) mem[i] = W'(16'h1000 + i);

        #1;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_ra",    {28'd0, ra}, 32'd0);
        chk("rst_data",  {16'd0, bus.out_data}, 32'd0);
        chk("rst_addr",  {28'd0, bus.out_addr}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick();

        do_dump(2, 5, 100, -1, 1'b0);
        do_dump(14, 1, 100, -1, 1'b0);
        do_dump(7, 7, 100, -1, 1'b0);
        do_dump(4, 6, 100, 1, 1'b0);

        // Abort in the SEND of the second word of 0..9
        first = RB'(0);
        last  = RB'(9);
        bus.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("abort_w0", {28'd0, bus.out_addr}, 32'd0);
        tick();
        tick();
        chk("abort_w1_valid", {31'd0, bus.out_valid}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bus.out_ready = 1'b0;
        chk("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_done",  {31'd0, done}, 32'd0);
        tick();
        chk("abort_done2", {31'd0, done}, 32'd0);
        do_dump(3, 3, 100, -1, 1'b0);

        // Asynchronous reset while a word is waiting in SEND
        first = RB'(2);
        last  = RB'(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rsend_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_busy",  {31'd0, busy}, 32'd0);
        chk("arst_done",  {31'd0, done}, 32'd0);
        chk("arst_ra",    {28'd0, ra}, 32'd0);
        chk("arst_data",  {16'd0, bus.out_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("arst_idle_busy",  {31'd0, busy}, 32'd0);
        chk("arst_idle_valid", {31'd0, bus.out_valid}, 32'd0);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NREG; i++) mem[i] = W'($urandom);
            do_dump($urandom_range(NREG - 1), $urandom_range(NREG - 1),
                    $urandom_range(30, 100), -1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
